// File: rtl/synth_env_pkg.sv
// Shared constants for the synth voice envelope: state encodings and default
// step sizes/levels used by envelope_sequencer.
package synth_env_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StAttack  = 3'd1;
    localparam logic [2:0] StDecay   = 3'd2;
    localparam logic [2:0] StSustain = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    localparam int unsigned DefAmpW         = 8;
    localparam int unsigned DefTickDiv      = 50000;
    localparam int unsigned DefAttackStep   = 4;
    localparam int unsigned DefDecayStep    = 2;
    localparam int unsigned DefSustainLevel = 192;
    localparam int unsigned DefReleaseStep  = 1;
    localparam int unsigned DefSustainUnit  = 64;

    // 15 * 64 = 960 fits in 10 bits
    localparam int unsigned SusCntW = 10;

endpackage

// File: rtl/env_tick_prescaler.sv
// Free-running divider producing a one-cycle envelope tick every TICK_DIV clocks.
module env_tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/envelope_sequencer.sv
// ADSR envelope controller: key edges steer the state machine, prescaler ticks
// step the amplitude with saturating arithmetic, SUSTAIN is optionally timed.
module envelope_sequencer
    import synth_env_pkg::*;
#(
    parameter int unsigned TICK_DIV      = DefTickDiv,
    parameter int unsigned AMP_W         = DefAmpW,
    parameter int unsigned ATTACK_STEP   = DefAttackStep,
    parameter int unsigned DECAY_STEP    = DefDecayStep,
    parameter int unsigned SUSTAIN_LEVEL = DefSustainLevel,
    parameter int unsigned RELEASE_STEP  = DefReleaseStep,
    parameter int unsigned SUSTAIN_UNIT  = DefSustainUnit
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             key_on,
    input  logic [3:0]       sustain_time,
    output logic [AMP_W-1:0] amplitude,
    output logic [2:0]       env_state,
    output logic             busy,
    output logic             note_done
);

    localparam logic [AMP_W:0] FullScale = {1'b0, {AMP_W{1'b1}}};

    logic               tick, rise, fall, key_q;
    logic [2:0]         state_q, state_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic [SusCntW-1:0] sus_q, sus_d;
    logic               done_d, done_q, busy_q;
    logic [AMP_W:0]     att_sum;

    env_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign rise = key_on & ~key_q;
    assign fall = ~key_on & key_q;

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        sus_d   = sus_q;
        done_d  = 1'b0;
        att_sum = {1'b0, amp_q} + (AMP_W+1)'(ATTACK_STEP);

        // Edges take priority over ticks; a retrigger keeps the current amplitude.
        if (rise) begin
            state_d = StAttack;
        end else if (fall && (state_q == StAttack || state_q == StDecay ||
                              state_q == StSustain)) begin
            state_d = StRelease;
        end else if (tick) begin
            case (state_q)
                StAttack: begin
                    if (att_sum >= FullScale) begin
                        amp_d   = FullScale[AMP_W-1:0];
                        state_d = StDecay;
                    end else begin
                        amp_d = att_sum[AMP_W-1:0];
                    end
                end
                StDecay: begin
                    if ({1'b0, amp_q} <= (AMP_W+1)'(SUSTAIN_LEVEL + DECAY_STEP)) begin
                        amp_d   = AMP_W'(SUSTAIN_LEVEL);
                        state_d = StSustain;
                        sus_d   = SusCntW'(sustain_time) * SusCntW'(SUSTAIN_UNIT);
                    end else begin
                        amp_d = amp_q - AMP_W'(DECAY_STEP);
                    end
                end
                StSustain: begin
                    // A zero count means hold until the key is released.
                    if (sus_q != '0) begin
                        sus_d = sus_q - SusCntW'(1);
                        if (sus_q == SusCntW'(1)) begin
                            state_d = StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (amp_q <= AMP_W'(RELEASE_STEP)) begin
                        amp_d   = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        amp_d = amp_q - AMP_W'(RELEASE_STEP);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q   <= 1'b0;
            state_q <= StIdle;
            amp_q   <= '0;
            sus_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            key_q   <= key_on;
            state_q <= state_d;
            amp_q   <= amp_d;
            sus_q   <= sus_d;
            done_q  <= done_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    assign amplitude = amp_q;
    assign env_state = state_q;
    assign busy      = busy_q;
    assign note_done = done_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Self-checking bench for envelope_sequencer: directed note scenarios plus random
// key gating, all compared every cycle against a behavioural ADSR model.
module tb_envelope_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       key_on = 1'b0;
    logic [3:0] sustain_time = 4'd0;
    logic [7:0] amplitude;
    logic [2:0] env_state;
    logic       busy;
    logic       note_done;

    always #5 clk = ~clk;

    envelope_sequencer #(
        .TICK_DIV (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_on       (key_on),
        .sustain_time (sustain_time),
        .amplitude    (amplitude),
        .env_state    (env_state),
        .busy         (busy),
        .note_done    (note_done)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    int m_amp, m_state, m_sus, m_cyc, m_key, m_done, m_tick;
    int done_cnt;
    int ticks;
    int t0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_amp = 0; m_state = 0; m_sus = 0; m_cyc = 0; m_key = 0; m_done = 0; m_tick = 0;
    endtask

    task automatic model_edge(input int k, input int st);
        int rise, fall;
        m_tick = ((m_cyc % 4) == 3) ? 1 : 0;
        m_cyc++;
        rise = (k == 1 && m_key == 0) ? 1 : 0;
        fall = (k == 0 && m_key == 1) ? 1 : 0;
        m_key = k;
        m_done = 0;
        if (rise == 1) begin
            m_state = 1;
        end else if (fall == 1 && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (m_tick == 1) begin
            case (m_state)
                1: begin
                    m_amp = (m_amp + 4 > 255) ? 255 : m_amp + 4;
                    if (m_amp == 255) m_state = 2;
                end
                2: begin
                    m_amp = (m_amp - 2 < 192) ? 192 : m_amp - 2;
                    if (m_amp == 192) begin
                        m_state = 3;
                        m_sus = st * 64;
                    end
                end
                3: begin
                    if (m_sus > 0) begin
                        m_sus--;
                        if (m_sus == 0) m_state = 4;
                    end
                end
                4: begin
                    m_amp = (m_amp - 1 < 0) ? 0 : m_amp - 1;
                    if (m_amp == 0) begin
                        m_state = 0;
                        m_done = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(int'(key_on), int'(sustain_time));
        #1;
        check_eq("amplitude", int'(amplitude), m_amp);
        check_eq("env_state", int'(env_state), m_state);
        check_eq("busy", int'(busy), (m_state != 0) ? 1 : 0);
        check_eq("note_done", int'(note_done), m_done);
        done_cnt += int'(note_done);
    endtask

    task automatic wait_leave(input string tag, input int from, output int n);
        n = 0;
        for (int i = 0; i < 8000 && int'(env_state) == from; i++) begin
            step();
            n += m_tick;
        end
        check_eq({tag, "_left"}, (int'(env_state) != from) ? 1 : 0, 1);
    endtask

    task automatic go_idle();
        key_on = 1'b0;
        for (int i = 0; i < 8000 && m_state != 0; i++) step();
        step();
    endtask

    initial begin
        model_reset();
        done_cnt = 0;
        #2 reset_n = 1'b0;
        #10;
        check_eq("rst_amplitude", int'(amplitude), 0);
        check_eq("rst_env_state", int'(env_state), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_note_done", int'(note_done), 0);
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        repeat (3) step();

        // Full note, timed sustain, key held throughout
        sustain_time = 4'd3;
        key_on = 1'b1;
        done_cnt = 0;
        step();
        check_eq("full_rise_state", int'(env_state), 1);
        wait_leave("full_attack", 1, ticks);
        check_eq("full_attack_ticks", ticks, 64);
        check_eq("full_decay_state", int'(env_state), 2);
        wait_leave("full_decay", 2, ticks);
        check_eq("full_decay_ticks", ticks, 32);
        check_eq("full_sustain_amp", int'(amplitude), 192);
        wait_leave("full_sustain", 3, ticks);
        check_eq("full_sustain_ticks", ticks, 192);
        check_eq("full_auto_release", int'(env_state), 4);
        wait_leave("full_release", 4, ticks);
        check_eq("full_release_ticks", ticks, 192);
        repeat (40) step();
        check_eq("full_done_pulses", done_cnt, 1);
        check_eq("full_no_retrigger", int'(env_state), 0);
        key_on = 1'b0;
        repeat (3) step();

        // Hold mode: sustain_time 0 holds until key released
        sustain_time = 4'd0;
        key_on = 1'b1;
        step();
        wait_leave("hold_attack", 1, ticks);
        wait_leave("hold_decay", 2, ticks);
        repeat (2000) step();
        check_eq("hold_state", int'(env_state), 3);
        check_eq("hold_amp", int'(amplitude), 192);
        key_on = 1'b0;
        step();
        check_eq("hold_release_edge", int'(env_state), 4);
        wait_leave("hold_release", 4, ticks);
        check_eq("hold_release_ticks", ticks, 192);
        step();

        // Early release from ATTACK at amplitude 100
        key_on = 1'b1;
        done_cnt = 0;
        step();
        for (int i = 0; i < 400 && m_amp != 100; i++) step();
        check_eq("early_pre_amp", int'(amplitude), 100);
        key_on = 1'b0;
        step();
        check_eq("early_state", int'(env_state), 4);
        check_eq("early_amp", int'(amplitude), 100);
        wait_leave("early_release", 4, ticks);
        check_eq("early_release_ticks", ticks, 100);
        repeat (10) step();
        check_eq("early_done_pulses", done_cnt, 1);

        // Retrigger in RELEASE at 150, rise placed on a tick cycle
        key_on = 1'b1;
        step();
        wait_leave("retrig_attack0", 1, ticks);
        wait_leave("retrig_decay0", 2, ticks);
        key_on = 1'b0;
        step();
        for (int i = 0; i < 400 && m_amp != 150; i++) step();
        for (int i = 0; i < 8 && (m_cyc % 4) != 3; i++) step();
        check_eq("retrig_pre_amp", int'(amplitude), 150);
        key_on = 1'b1;
        step();
        check_eq("coincide_tick", m_tick, 1);
        check_eq("coincide_state", int'(env_state), 1);
        check_eq("coincide_amp", int'(amplitude), 150);
        wait_leave("retrig_attack", 1, ticks);
        check_eq("retrig_attack_ticks", ticks, 27);
        go_idle();

        // Live change of sustain_time mid-SUSTAIN does not alter duration
        sustain_time = 4'd3;
        key_on = 1'b1;
        step();
        wait_leave("live_attack", 1, ticks);
        wait_leave("live_decay", 2, ticks);
        t0 = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            t0 += m_tick;
        end
        sustain_time = 4'd9;
        wait_leave("live_sustain", 3, ticks);
        check_eq("live_sustain_ticks", t0 + ticks, 192);
        go_idle();

        // Asynchronous reset mid-ATTACK at amplitude 40
        key_on = 1'b1;
        done_cnt = 0;
        step();
        for (int i = 0; i < 200 && m_amp != 40; i++) step();
        check_eq("arst_pre_amp", int'(amplitude), 40);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_amplitude", int'(amplitude), 0);
        check_eq("arst_env_state", int'(env_state), 0);
        check_eq("arst_busy", int'(busy), 0);
        key_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 done_cnt += int'(note_done);
        end
        @(negedge clk) reset_n = 1'b1;
        model_reset();
        repeat (5) step();
        check_eq("arst_no_done", done_cnt, 0);

        // Random gating and sustain codes
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 149) == 0) key_on = ~key_on;
            sustain_time = 4'($urandom_range(0, 4));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/envelope_sequencer.md
Name: envelope_sequencer

Overview:
ADSR-style envelope controller for the synth voice path. It sequences IDLE/ATTACK/DECAY/SUSTAIN/RELEASE from the key_on level. The SUSTAIN dwell time comes from the 4-bit sustain time produced by SustainVariable. Its amplitude output scales the oscillator sample downstream, so it is the block that drives the sustain-time setting through a note.

Parameters:
TICK_DIV, 50000, clk cycles per envelope tick (1 kHz at 50 MHz); benches use 4
AMP_W, 8, amplitude width; full scale = 2^AMP_W-1 = 255
ATTACK_STEP, 4, amplitude increment per tick in ATTACK
DECAY_STEP, 2, amplitude decrement per tick in DECAY
SUSTAIN_LEVEL, 192, amplitude held in SUSTAIN
RELEASE_STEP, 1, amplitude decrement per tick in RELEASE
SUSTAIN_UNIT, 64, ticks per LSB of sustain_time

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
key_on  input  1  note gate level, synchronous to clk
sustain_time  input  4  sustain duration code from SustainVariable (0 = hold while key held)
amplitude  output  AMP_W  current envelope level
env_state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
busy  output  1  high whenever env_state != IDLE
note_done  output  1  one-cycle pulse when RELEASE reaches 0

Behaviour:
- Reset (asynchronous, reset_n low) forces the following: amplitude=0, env_state=IDLE, busy=0, note_done=0, prescaler=0, sustain counter=0, key_q=0. Reset mid-note aborts with no note_done pulse.
- Prescaler: free-running 0..TICK_DIV-1. tick=1 for the single cycle where the count equals TICK_DIV-1, then wraps to 0. It is not restarted by key events.
- Key edges: key_q registers key_on every cycle. rise = key_on & ~key_q; fall = ~key_on & key_q. Edges act in the same clock edge they are sampled, so env_state changes at the edge where key_on is first seen high or low.
- Priority per cycle: rise > fall > tick-driven step/transition. If an edge and a tick coincide, the edge wins and no amplitude step is applied that cycle.
- rise from any state (including RELEASE or ATTACK) -> ATTACK. Amplitude is kept as-is: retrigger, no jump to 0.
- fall in ATTACK/DECAY/SUSTAIN -> RELEASE. fall in IDLE/RELEASE is ignored.
- ATTACK: on tick, amp = min(amp+ATTACK_STEP, 255), computed at AMP_W+1 bits. When the new value is 255 -> DECAY on the same edge.
- DECAY: on tick, amp = max(amp-DECAY_STEP, SUSTAIN_LEVEL). When the new value equals SUSTAIN_LEVEL -> SUSTAIN, and the sustain counter loads sustain_time*SUSTAIN_UNIT (10 bits). sustain_time is sampled only at this entry; later changes do not affect the note in progress.
- SUSTAIN: amplitude is held.
  - Loaded count 0: stays until fall.
  - Otherwise the counter decrements on tick. The tick that takes it to 0 -> RELEASE, even if key_on is still high.
- RELEASE: on tick, amp = max(amp-RELEASE_STEP, 0). The new value 0 -> IDLE with note_done=1 for exactly that one cycle.
- IDLE: amplitude is 0 and ticks are ignored.
- key_on held high through IDLE after an auto-release does not retrigger; a new rise is needed.
- All outputs are registered. amplitude and env_state update on the same edge.

Decomposition:
- Package synth_env_pkg: the env_state encodings (IDLE..RELEASE) as localparam constants, the default step/level constants, and the AMP_W default.
- One sub-module, env_tick_prescaler (parameter TICK_DIV; ports clk, reset_n, tick), instantiated once.
- The FSM, saturating arithmetic and sustain counter live in envelope_sequencer.

Test Plan:
All scenarios use TICK_DIV=4 and default steps.
- Reset: reset_n low mid-ATTACK with amp=40 -> amplitude=0, env_state=0 and busy=0 immediately (asynchronous); no note_done pulse.
- Full note with sustain_time=3 and key held:
  - ATTACK reaches 255 on the 64th tick, then DECAY.
  - DECAY reaches 192 on the 32nd tick, then SUSTAIN.
  - SUSTAIN lasts 192 ticks, then RELEASE (key still high).
  - RELEASE hits 0 after 192 ticks; note_done pulses once and env_state=0.
- Hold mode: sustain_time=0 -> SUSTAIN holds 192 indefinitely (check 500 ticks). Dropping key_on -> RELEASE on that edge; 192 ticks later IDLE.
- Early release: drop key_on in ATTACK at amp=100 -> RELEASE from 100, then IDLE after 100 ticks with a single note_done.
- Retrigger: rise during RELEASE at amp=150 -> ATTACK starting at 150; 255 reached after 27 ticks.
- Coincidence and live change:
  - Force key_on rise on a tick cycle -> state becomes ATTACK and amplitude is not stepped that cycle.
  - Change sustain_time from 3 to 9 mid-SUSTAIN -> duration stays 192 ticks.
